// File: rtl/mul_seq_ctrl.sv
// Shift-add multiply sequencer: drives the shared ALU in add mode, one partial product per cycle.
// Latency: done pulses N edges after the start edge, N = max(1, msb index of mplier + 1), N <= WIDTH.
// Backpressure: none; start is taken only in IDLE (flush has priority), start while busy/done is dropped.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start, flush         request a multiply (IDLE only) / abandon the operation
//   mcand, mplier        operands, sampled with an accepted start
//   busy, done, product  RUN indicator, one-cycle completion pulse, low WIDTH bits of the product
//   alu_req/a/b/op       shared ALU request and operands (acc, shifted multiplicand, add opcode)
//   alu_result           combinational ALU result for the current alu_a/alu_b/alu_op
module mul_seq_ctrl #(
  parameter int          WIDTH   = 64,
  parameter logic [3:0]  ALU_ADD = 4'b0010,
  parameter int          CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]   mp_q, mp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mp_shr;

  assign mp_shr = mp_q >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          acc_d   = '0;
          mc_d    = mcand;
          mp_d    = mplier;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // A flush abandons the step entirely so acc keeps its last value.
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (mp_q[0]) acc_d = alu_result;
          mc_d  = mc_q << 1;
          mp_d  = mp_shr;
          cnt_d = cnt_q + 1'b1;
          // Stop early once no multiplier bits remain; the counter bound
          // covers the case where the top multiplier bit is set.
          if (mp_shr == '0 || cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE) && !flush;
  assign product = acc_q;
  assign alu_req = (state_q == RUN);
  assign alu_a   = acc_q;
  assign alu_b   = mc_q;
  assign alu_op  = (state_q == RUN) ? ALU_ADD : 4'b0000;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural 64-bit adder standing in for the shared ALU.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [63:0] mcand;
  logic [63:0] mplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        alu_req;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Add when asked to; otherwise return junk so any use of the result outside RUN shows up.
  assign alu_result = (alu_op == 4'b0010) ? (alu_a + alu_b) : 64'hDEAD_BEEF_0BAD_F00D;

  mul_seq_ctrl #(.WIDTH(64), .ALU_ADD(4'b0010), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flush      (flush),
    .mcand      (mcand),
    .mplier     (mplier),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_req    (alu_req),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one multiply from IDLE and follow it to completion. Inputs change and
  // outputs are sampled on the falling edge.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input int exp_n, input logic [63:0] exp_p);
    int run_cnt;
    int op_bad;
    bit got_done;
    run_cnt  = 0;
    op_bad   = 0;
    got_done = 1'b0;
    @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_first_alu_a"}, alu_a, 64'h0);
    chk({tag, "_first_alu_b"}, alu_b, a);
    for (int i = 0; i < 200 && !got_done; i++) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (busy) run_cnt++;
        if (!(busy && alu_req && alu_op == 4'b0010)) op_bad++;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
    chk({tag, "_run_cycles"}, 64'(run_cnt), 64'(exp_n));
    chk({tag, "_run_outputs_bad"}, 64'(op_bad), 64'd0);
    chk({tag, "_product"}, product, exp_p);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "_idle_alu"}, {59'd0, alu_req, alu_op}, 64'd0);
    chk({tag, "_product_held"}, product, exp_p);
  endtask

  initial begin
    int done_cnt;
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #12;
    chk("rst_busy",    64'(busy), 64'd0);
    chk("rst_done",    64'(done), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_alu",     {59'd0, alu_req, alu_op}, 64'd0);
    chk("rst_alu_ab",  alu_a | alu_b, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic operation, zero multiplier, and the full-width worst case.
    do_op("m3x5",   64'd3, 64'd5, 3, 64'd15);
    do_op("m0",     64'h1234, 64'd0, 1, 64'd0);
    do_op("mmax",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64, 64'd1);

    // Start while busy and while in DONE must be dropped.
    @(negedge clk);
    mcand = 64'd3; mplier = 64'd5; start = 1'b1;
    @(negedge clk);               // RUN cycle 1
    start = 1'b0;
    @(negedge clk);               // RUN cycle 2
    mcand = 64'd7; mplier = 64'd7; start = 1'b1;
    @(negedge clk);               // RUN cycle 3
    @(negedge clk);               // DONE, start still high
    chk("ign_done_pulse", 64'(done), 64'd1);
    chk("ign_product",    product, 64'd15);
    @(negedge clk);               // IDLE
    start = 1'b0;
    chk("ign_not_restarted", 64'(busy), 64'd0);
    chk("ign_product_held",  product, 64'd15);
    do_op("m7x7", 64'd7, 64'd7, 3, 64'd49);

    // Flush in the 4th RUN cycle.
    @(negedge clk);
    mcand = 64'd9; mplier = 64'h80; start = 1'b1;
    @(negedge clk);               // RUN 1
    start = 1'b0;
    @(negedge clk);               // RUN 2
    @(negedge clk);               // RUN 3
    @(negedge clk);               // RUN 4
    chk("fl_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy_after", 64'(busy), 64'd0);
    chk("fl_acc_kept",   product, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    chk("fl_no_done", 64'(done_cnt), 64'd0);
    do_op("m9x2", 64'd9, 64'd2, 2, 64'd18);

    // Asynchronous reset in the 5th RUN cycle.
    @(negedge clk);
    mcand = 64'd9; mplier = 64'h80; start = 1'b1;
    @(negedge clk);               // RUN 1
    start = 1'b0;
    repeat (4) @(negedge clk);    // RUN 5
    chk("ar_busy_before", 64'(busy), 64'd1);
    chk("ar_alu_b_before", alu_b, 64'd144);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy",    64'(busy), 64'd0);
    chk("ar_done",    64'(done), 64'd0);
    chk("ar_product", product, 64'd0);
    chk("ar_alu",     {59'd0, alu_req, alu_op}, 64'd0);
    chk("ar_alu_ab",  alu_a | alu_b, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("m2x2", 64'd2, 64'd2, 2, 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
